// File: rtl/bicubic_scan_ctrl.sv
// Bicubic resize sequencer: walks target pixels in raster order, issues a
// clamped 4x4 ImgROM window per pixel, forwards tap/fraction info to the
// interpolation datapath and stores each result into ResultSRAM.
module bicubic_scan_ctrl #(
  parameter int IMG_W  = 100,
  parameter int ROM_AW = 14,
  parameter int RAM_AW = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [6:0]        H0,
  input  logic [6:0]        V0,
  input  logic [4:0]        SW,
  input  logic [4:0]        SH,
  input  logic [5:0]        TW,
  input  logic [5:0]        TH,
  output logic              ROM_RD,
  output logic [ROM_AW-1:0] ROM_A,
  output logic              TAP_VALID,
  output logic [3:0]        TAP_IDX,
  output logic [5:0]        FX_NUM,
  output logic [5:0]        FY_NUM,
  output logic [5:0]        FX_DEN,
  output logic [5:0]        FY_DEN,
  input  logic              RES_VALID,
  input  logic [7:0]        RES_D,
  output logic              SRAM_WEN,
  output logic [RAM_AW-1:0] SRAM_A,
  output logic [7:0]        SRAM_D,
  output logic              DONE
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  // Clamp a signed source coordinate into the image [0, IMG_W-1].
  function automatic logic [6:0] clamp_pix(input logic signed [8:0] v);
    if (v < 9'sd0)
      return 7'd0;
    else if (v > 9'(IMG_W - 1))
      return 7'(IMG_W - 1);
    else
      return v[6:0];
  endfunction

  logic [2:0] state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [5:0] tx_q, tx_d, ty_q, ty_d;
  logic [5:0] ix_q, ix_d, iy_q, iy_d;
  logic [5:0] rx_q, rx_d, ry_q, ry_d;
  logic       tap_valid_q;
  logic [3:0] tap_idx_q;

  // Job configuration and captured result carry no reset: outputs that
  // expose them are gated by state, which is reset.
  logic [6:0] h0_q, v0_q;
  logic [4:0] sw_q, sh_q;
  logic [5:0] tw_q, th_q;
  logic [7:0] res_q;

  logic              load_cfg, capture_res, active;
  logic [6:0]        rx_sum, ry_sum;
  logic signed [8:0] col_s, row_s;
  logic [6:0]        col_c, row_c;
  logic [11:0]       pix_addr;

  assign load_cfg    = ((state_q == S_IDLE) || (state_q == S_FIN)) && START;
  assign capture_res = (state_q == S_WAIT) && RES_VALID;
  assign active      = (state_q != S_IDLE);

  // Window tap position, offset by -1 so the 4x4 window straddles the source point.
  assign col_s = $signed({2'b00, h0_q}) + $signed({3'b000, ix_q})
               + $signed({7'b0, k_q[1:0]}) - 9'sd1;
  assign row_s = $signed({2'b00, v0_q}) + $signed({3'b000, iy_q})
               + $signed({7'b0, k_q[3:2]}) - 9'sd1;
  assign col_c = clamp_pix(col_s);
  assign row_c = clamp_pix(row_s);

  assign pix_addr = ({6'b0, ty_q} * {6'b0, tw_q}) + {6'b0, tx_q};

  assign ROM_RD    = (state_q == S_FETCH);
  assign ROM_A     = ROM_RD ? (ROM_AW'(row_c) * ROM_AW'(IMG_W) + ROM_AW'(col_c))
                            : '0;
  assign TAP_VALID = tap_valid_q;
  assign TAP_IDX   = tap_idx_q;
  assign FX_NUM    = rx_q;
  assign FY_NUM    = ry_q;
  assign FX_DEN    = active ? (tw_q - 6'd1) : 6'd0;
  assign FY_DEN    = active ? (th_q - 6'd1) : 6'd0;
  assign SRAM_WEN  = (state_q == S_WRITE);
  assign SRAM_A    = SRAM_WEN ? RAM_AW'(pix_addr) : '0;
  assign SRAM_D    = SRAM_WEN ? res_q : 8'd0;
  assign DONE      = (state_q == S_FIN);

  // Next-state and incremental source-position stepping (no divider).
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    ix_d    = ix_q;
    iy_d    = iy_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rx_sum  = {1'b0, rx_q} + {2'b00, sw_q} - 7'd1;
    ry_sum  = {1'b0, ry_q} + {2'b00, sh_q} - 7'd1;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (START) begin
          state_d = S_FETCH;
          k_d     = 4'd0;
          tx_d    = 6'd0;
          ty_d    = 6'd0;
          ix_d    = 6'd0;
          iy_d    = 6'd0;
          rx_d    = 6'd0;
          ry_d    = 6'd0;
        end
      end
      S_FETCH: begin
        k_d = k_q + 4'd1;
        if (k_q == 4'd15)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (RES_VALID)
          state_d = S_WRITE;
      end
      S_WRITE: begin
        if (tx_q == tw_q - 6'd1) begin
          tx_d = 6'd0;
          ix_d = 6'd0;
          rx_d = 6'd0;
          ty_d = ty_q + 6'd1;
          // SH<=TH guarantees one conditional subtraction is enough.
          if (ry_sum >= {1'b0, th_q} - 7'd1) begin
            ry_d = 6'(ry_sum - ({1'b0, th_q} - 7'd1));
            iy_d = iy_q + 6'd1;
          end else begin
            ry_d = ry_sum[5:0];
          end
          state_d = (ty_q == th_q - 6'd1) ? S_FIN : S_FETCH;
        end else begin
          tx_d = tx_q + 6'd1;
          if (rx_sum >= {1'b0, tw_q} - 7'd1) begin
            rx_d = 6'(rx_sum - ({1'b0, tw_q} - 7'd1));
            ix_d = ix_q + 6'd1;
          end else begin
            rx_d = rx_sum[5:0];
          end
          state_d = S_FETCH;
        end
        k_d = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, counters and the one-cycle tap delay line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      k_q         <= 4'd0;
      tx_q        <= 6'd0;
      ty_q        <= 6'd0;
      ix_q        <= 6'd0;
      iy_q        <= 6'd0;
      rx_q        <= 6'd0;
      ry_q        <= 6'd0;
      tap_valid_q <= 1'b0;
      tap_idx_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      ix_q        <= ix_d;
      iy_q        <= iy_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      tap_valid_q <= ROM_RD;
      tap_idx_q   <= k_q;
    end
  end

  // Configuration latch at job start and result capture in WAIT.
  always_ff @(posedge CLK) begin
    if (load_cfg) begin
      h0_q <= H0;
      v0_q <= V0;
      sw_q <= SW;
      sh_q <= SH;
      tw_q <= TW;
      th_q <= TH;
    end
    if (capture_res)
      res_q <= RES_D;
  end

endmodule

// File: tb/tb_bicubic_scan_ctrl.sv
// Directed bench for bicubic_scan_ctrl: identity walk, corner and far-edge
// clamping, upscale fractions, backpressure and mid-job reset.
module tb_bicubic_scan_ctrl;

  logic        CLK, RST, START;
  logic [6:0]  H0, V0;
  logic [4:0]  SW, SH;
  logic [5:0]  TW, TH;
  logic        ROM_RD;
  logic [13:0] ROM_A;
  logic        TAP_VALID;
  logic [3:0]  TAP_IDX;
  logic [5:0]  FX_NUM, FY_NUM, FX_DEN, FY_DEN;
  logic        RES_VALID;
  logic [7:0]  RES_D;
  logic        SRAM_WEN;
  logic [11:0] SRAM_A;
  logic [7:0]  SRAM_D;
  logic        DONE;

  int n_cmp = 0;
  int n_err = 0;
  int ix_e[5] = '{0, 0, 1, 1, 2};
  int rx_e[5] = '{0, 2, 0, 2, 0};
  logic [13:0] taps[16];

  bicubic_scan_ctrl #(.IMG_W(100), .ROM_AW(14), .RAM_AW(12)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .H0(H0), .V0(V0), .SW(SW), .SH(SH), .TW(TW), .TH(TH),
    .ROM_RD(ROM_RD), .ROM_A(ROM_A), .TAP_VALID(TAP_VALID), .TAP_IDX(TAP_IDX),
    .FX_NUM(FX_NUM), .FY_NUM(FY_NUM), .FX_DEN(FX_DEN), .FY_DEN(FY_DEN),
    .RES_VALID(RES_VALID), .RES_D(RES_D),
    .SRAM_WEN(SRAM_WEN), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_wen();
    int n;
    n = 0;
    while (SRAM_WEN !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("wen_timeout", SRAM_WEN, 1);
  endtask

  task automatic set_cfg(input int h, input int v, input int sw, input int sh,
                         input int tw, input int th);
    H0 = 7'(h); V0 = 7'(v); SW = 5'(sw); SH = 5'(sh); TW = 6'(tw); TH = 6'(th);
  endtask

  task automatic start_job();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Run remaining pixels with immediate results; RES_D = pixel index.
  task automatic run_job(input int first_p, input int npix, input bit frac0);
    RES_VALID = 1'b1;
    for (int p = first_p; p < npix; p++) begin
      RES_D = 8'(p);
      wait_wen();
      check("sram_a", SRAM_A, p);
      check("sram_d", SRAM_D, p);
      check("done_low", DONE, 0);
      if (frac0) begin
        check("fx_num0", FX_NUM, 0);
        check("fy_num0", FY_NUM, 0);
      end
      tick();
    end
    RES_VALID = 1'b0;
    check("done", DONE, 1);
    check("rom_rd_fin", ROM_RD, 0);
    check("wen_fin", SRAM_WEN, 0);
  endtask

  initial begin
    START = 0; RES_VALID = 0; RES_D = 0;
    set_cfg(10, 20, 4, 4, 4, 4);
    RST = 1'b1;
    #2 RST = 1'b0;
    tick(); tick();
    check("rst_rom_rd", ROM_RD, 0);
    check("rst_rom_a", ROM_A, 0);
    check("rst_tap_valid", TAP_VALID, 0);
    check("rst_wen", SRAM_WEN, 0);
    check("rst_done", DONE, 0);
    check("rst_fx_den", FX_DEN, 0);
    RST = 1'b1;
    tick();

    // Identity 4x4 at (10,20)
    start_job();
    check("id_rom_rd", ROM_RD, 1);
    check("id_a0", ROM_A, 1909);
    check("id_fx_den", FX_DEN, 3);
    tick();
    check("id_a1", ROM_A, 1910);
    check("id_tap_valid", TAP_VALID, 1);
    check("id_tap_idx0", TAP_IDX, 0);
    tick();
    check("id_a2", ROM_A, 1911);
    tick();
    check("id_a3", ROM_A, 1912);
    run_job(0, 16, 1'b1);

    // Corner clamp at (0,0)
    set_cfg(0, 0, 4, 4, 4, 4);
    start_job();
    check("corner_done_clr", DONE, 0);
    for (int k = 0; k < 16; k++) begin
      taps[k] = ROM_A;
      tick();
    end
    check("corner_t0", taps[0], 0);
    check("corner_t1", taps[1], 0);
    check("corner_t2", taps[2], 1);
    check("corner_t3", taps[3], 2);
    check("corner_t4", taps[4], 0);
    check("corner_t8", taps[8], 100);
    check("corner_last_tapv", TAP_VALID, 1);
    check("corner_last_tapidx", TAP_IDX, 15);
    check("corner_wait_rd", ROM_RD, 0);
    run_job(0, 16, 1'b1);

    // Far-edge clamp at (96,96)
    set_cfg(96, 96, 4, 4, 4, 4);
    start_job();
    RES_VALID = 1'b1;
    for (int p = 0; p < 15; p++) begin
      RES_D = 8'(p);
      wait_wen();
      check("far_sram_a", SRAM_A, p);
      tick();
    end
    check("far_p15_t0", ROM_A, 9898);
    for (int k = 0; k < 15; k++) tick();
    check("far_p15_rd", ROM_RD, 1);
    check("far_p15_t15", ROM_A, 9999);
    run_job(15, 16, 1'b0);

    // Upscale SW=3 -> TW=5, SH=TH=2
    set_cfg(10, 20, 3, 2, 5, 2);
    start_job();
    RES_VALID = 1'b1;
    for (int p = 0; p < 10; p++) begin
      RES_D = 8'(p);
      check("up_rom_a", ROM_A, (19 + p / 5) * 100 + 9 + ix_e[p % 5]);
      check("up_fx_num", FX_NUM, rx_e[p % 5]);
      check("up_fy_num", FY_NUM, 0);
      check("up_fx_den", FX_DEN, 4);
      check("up_fy_den", FY_DEN, 1);
      wait_wen();
      check("up_sram_a", SRAM_A, p);
      check("up_fx_hold", FX_NUM, rx_e[p % 5]);
      tick();
    end
    RES_VALID = 1'b0;
    check("up_done", DONE, 1);

    // Backpressure, stray RES_VALID, config change after START
    set_cfg(50, 50, 2, 2, 2, 2);
    start_job();
    H0 = 7'd0; V0 = 7'd0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) check("bp_a0_latched", ROM_A, 4949);
      if (k == 1) check("bp_a1_latched", ROM_A, 4950);
      check("bp_fetch_rd", ROM_RD, 1);
      check("bp_fetch_wen", SRAM_WEN, 0);
      RES_VALID = (k == 5);
      RES_D = 8'hEE;
      tick();
    end
    RES_VALID = 1'b0;
    for (int w = 0; w < 10; w++) begin
      check("bp_wait_rd", ROM_RD, 0);
      check("bp_wait_wen", SRAM_WEN, 0);
      tick();
    end
    RES_VALID = 1'b1;
    RES_D = 8'hA5;
    tick();
    RES_VALID = 1'b0;
    RES_D = 8'h3C;
    check("bp_wen", SRAM_WEN, 1);
    check("bp_sram_a", SRAM_A, 0);
    check("bp_sram_d", SRAM_D, 8'hA5);
    tick();
    check("bp_wen_pulse", SRAM_WEN, 0);
    check("bp_next_fetch", ROM_RD, 1);
    run_job(1, 4, 1'b0);
    tick(); tick();
    check("bp_done_hold", DONE, 1);

    // Reset mid-FETCH at tap 7, then a clean rerun
    set_cfg(10, 20, 4, 4, 4, 4);
    start_job();
    for (int k = 0; k < 7; k++) tick();
    check("rr_a7", ROM_A, 2012);
    #2 RST = 1'b0;
    #1;
    check("rr_rom_rd", ROM_RD, 0);
    check("rr_rom_a", ROM_A, 0);
    check("rr_tap_valid", TAP_VALID, 0);
    check("rr_wen", SRAM_WEN, 0);
    check("rr_done", DONE, 0);
    check("rr_fx_den", FX_DEN, 0);
    tick(); tick();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_idle_rd", ROM_RD, 0);
      check("rr_idle_wen", SRAM_WEN, 0);
    end
    start_job();
    check("rr_restart_a0", ROM_A, 1909);
    run_job(0, 16, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
